// File: rtl/rd_arbiter.sv
// -----------------------------------------------------------------------------
// rd_arbiter
//
// Round-robin arbiter and sequencer in front of one shared read-handshake
// engine. It picks one requester, pulses the engine's go for one cycle, waits
// for the engine's ds strobe (or a timeout), and then returns a one-cycle
// done or err pulse to that requester. This block is the only driver of the
// engine's go.
//
// Handshake with clients: a client raises req[i] and holds it until it sees
// done[i] or err[i] for one cycle. gnt[i] is high from the ISSUE cycle through
// the RELEASE cycle inclusive, and gnt_id holds the matching binary index
// (0 when idle). A grant is never changed or withdrawn mid-transaction, even
// if the grantee drops req. A reset in the middle of a transaction drops it
// silently, with no done or err.
//
// Parameters:
//   N        number of requesters (2..16)
//   TIMEOUT  maximum cycles spent in WAIT_DS before abort (>= 4)
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   req      per-requester request level
//   gnt      one-hot grant
//   gnt_id   binary index of the current grantee
//   done     one-cycle completion pulse to the grantee
//   err      one-cycle timeout pulse to the grantee
//   busy     high in every state except IDLE
//   go       one-cycle start pulse to the read engine
//   eng_rd   read engine is in READ or WAIT
//   eng_ds   read engine is in DONE (one cycle)
//
// Every output is decoded from state and registers only. No input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module rd_arbiter #(
   parameter  int N       = 4,
   parameter  int TIMEOUT = 64,
   localparam int IDW     = $clog2(N),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic [N-1:0]   done,
   output logic [N-1:0]   err,
   output logic           busy,
   output logic           go,
   input  logic           eng_rd,
   input  logic           eng_ds
);

   // One extra bit so that ptr + offset can be reduced modulo N without
   // overflow, also for values of N that are not a power of two.
   localparam int JW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_DS = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_n;

   logic [N-1:0]   gnt_q;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] ptr;
   logic [CW-1:0]  cnt;
   logic           st_err;

   logic           win_found;
   logic [IDW-1:0] win_id;
   logic [N-1:0]   win_oh;
   logic [JW-1:0]  j;
   logic           timeout_hit;

   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // Winner search: the first set bit of req at or above ptr, wrapping
   // modulo N. The loop scans the offsets from the highest down to zero, so
   // the smallest offset that has a request is written last and wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      j         = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = {1'b0, ptr} + JW'(i);
         if (j >= JW'(N)) begin
            j = j - JW'(N);
         end
         if (req[j[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = j[IDW-1:0];
         end
      end
      win_oh         = '0;
      win_oh[win_id] = 1'b1;
   end

   // Next state. IDLE will not start a new transaction while the engine is
   // still busy, for example when it is stuck after a timeout.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (win_found && !eng_rd && !eng_ds) state_n = ISSUE;
         ISSUE:   state_n = WAIT_DS;
         WAIT_DS: if (eng_ds || timeout_hit) state_n = RELEASE;
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         gnt_q  <= '0;
         id_q   <= '0;
         ptr    <= '0;
         cnt    <= '0;
         st_err <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (state_n == ISSUE) begin
                  gnt_q <= win_oh;
                  id_q  <= win_id;
               end
            end
            ISSUE: begin
               cnt <= '0;
            end
            WAIT_DS: begin
               // The counter saturates instead of wrapping.
               if (cnt != '1) cnt <= cnt + CW'(1);
               // When ds and the timeout arrive together, ds wins and the
               // status is OK.
               if (state_n == RELEASE) st_err <= !eng_ds;
            end
            RELEASE: begin
               ptr   <= (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
               gnt_q <= '0;
               id_q  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = id_q;
   assign go     = (state == ISSUE);
   assign busy   = (state != IDLE);
   assign done   = (state == RELEASE && !st_err) ? gnt_q : '0;
   assign err    = (state == RELEASE &&  st_err) ? gnt_q : '0;

endmodule

// File: tb/tb_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_arbiter
//
// Testbench for rd_arbiter. It drives two instances:
//   dut    TIMEOUT=64, used for round robin, timing, wait stretch and reset
//   dut_t  TIMEOUT=8,  used for timeout, stuck engine and the ds/timeout tie
//
// Each instance is connected to a behavioural read engine:
//   go -> READ -> WAIT (stays for 'extra' cycles, or forever while 'stuck')
//      -> DONE (ds for one cycle) -> IDLE
// With extra = 0, ds arrives three cycles after go.
//
// Expected completions ({is_err, index}) are pushed when a request is driven.
// They are popped and compared whenever the instance pulses done or err.
// -----------------------------------------------------------------------------
module tb_rd_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int W   = 3;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;

   logic [N-1:0]   req    [2];
   logic [N-1:0]   gnt    [2];
   logic [IDW-1:0] gnt_id [2];
   logic [N-1:0]   done   [2];
   logic [N-1:0]   err    [2];
   logic           busy   [2];
   logic           go     [2];
   logic           eng_rd [2];
   logic           eng_ds [2];

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   logic [N-1:0] held_gnt [2];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   rd_arbiter #(.N(N), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req(req[0]), .gnt(gnt[0]), .gnt_id(gnt_id[0]),
      .done(done[0]), .err(err[0]), .busy(busy[0]), .go(go[0]),
      .eng_rd(eng_rd[0]), .eng_ds(eng_ds[0])
   );

   rd_arbiter #(.N(N), .TIMEOUT(8)) dut_t (
      .clk(clk), .rst(rst), .req(req[1]), .gnt(gnt[1]), .gnt_id(gnt_id[1]),
      .done(done[1]), .err(err[1]), .busy(busy[1]), .go(go[1]),
      .eng_rd(eng_rd[1]), .eng_ds(eng_ds[1])
   );

   // ---------------- read engine models ----------------
   typedef enum logic [1:0] {E_IDLE, E_READ, E_WAIT, E_DONE} eng_t;
   eng_t es    [2];
   int   ext   [2];
   int   extra [2];
   logic stuck [2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            es[k]  <= E_IDLE;
            ext[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            case (es[k])
               E_IDLE: if (go[k]) begin
                  es[k]  <= E_READ;
                  ext[k] <= extra[k];
               end
               E_READ: es[k] <= E_WAIT;
               E_WAIT: begin
                  if (stuck[k])        es[k]  <= E_WAIT;
                  else if (ext[k] > 0) ext[k] <= ext[k] - 1;
                  else                 es[k]  <= E_DONE;
               end
               default: es[k] <= E_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         eng_rd[k] = (es[k] == E_READ) || (es[k] == E_WAIT);
         eng_ds[k] = (es[k] == E_DONE);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic push_exp(input int k, input logic is_err, input logic [IDW-1:0] idx);
      if (k == 0) exp_q0.push_back({is_err, idx});
      else        exp_q1.push_back({is_err, idx});
   endtask

   task automatic mon_one(input int k);
      logic [W-1:0] e;
      logic         ok;
      logic [N-1:0] ed;
      logic [N-1:0] ee;
      e  = '0;
      ok = 1'b0;
      if (go[k]) begin
         check($sformatf("gnt_matches_id%0d", k), 32'(gnt[k]), 32'(onehot(gnt_id[k])));
         held_gnt[k] = gnt[k];
      end
      if ((done[k] | err[k]) != '0) begin
         if (k == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
         if (k == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
         check($sformatf("sb_expected%0d", k), 32'(ok), 32'(1));
         if (ok) begin
            ed = e[W-1] ? '0 : onehot(e[IDW-1:0]);
            ee = e[W-1] ? onehot(e[IDW-1:0]) : '0;
            check($sformatf("sb_done%0d", k), 32'(done[k]), 32'(ed));
            check($sformatf("sb_err%0d", k), 32'(err[k]), 32'(ee));
            check($sformatf("gnt_stable%0d", k), 32'(gnt[k]), 32'(held_gnt[k]));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) mon_one(k);
      end
   end

   // ---------------- driver tasks ----------------
   // Drives one request and follows it until done/err, recording the
   // go/completion offsets relative to the IDLE cycle in which req was
   // first presented.
   task automatic run_one(input int k, input logic [N-1:0] reqv, input int budget,
                          output int go_off, output int comp_off, output logic [63:0] bm,
                          output int n_go, output logic [N-1:0] g_go);
      int c;
      int off;
      go_off   = -1;
      comp_off = -1;
      bm       = '0;
      n_go     = 0;
      g_go     = '0;
      @(negedge clk);
      req[k] = reqv;
      c      = cyc;
      bm[0]  = busy[k];
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         off = cyc - c;
         if (off < 64) bm[off[5:0]] = busy[k];
         if (go[k]) begin
            n_go++;
            if (go_off < 0) begin
               go_off = off;
               g_go   = gnt[k];
            end
         end
         if ((done[k] | err[k]) != '0) begin
            comp_off = off;
            break;
         end
      end
      req[k] = '0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int           go_off;
      int           comp_off;
      int           n_go;
      int           cnt_go;
      int           cnt_done;
      logic [63:0]  bm;
      logic [N-1:0] gg;

      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req[k]      = '0;
         extra[k]    = 0;
         stuck[k]    = 1'b0;
         held_gnt[k] = '0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_gnt",    32'(gnt[k]),    32'(0));
         check("rst_gnt_id", 32'(gnt_id[k]), 32'(0));
         check("rst_done",   32'(done[k]),   32'(0));
         check("rst_err",    32'(err[k]),    32'(0));
         check("rst_go",     32'(go[k]),     32'(0));
         check("rst_busy",   32'(busy[k]),   32'(0));
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Round robin with all four requests held: order 0,1,2,3,0.
      push_exp(0, 1'b0, 2'd0);
      push_exp(0, 1'b0, 2'd1);
      push_exp(0, 1'b0, 2'd2);
      push_exp(0, 1'b0, 2'd3);
      push_exp(0, 1'b0, 2'd0);
      req[0]   = 4'b1111;
      cnt_go   = 0;
      cnt_done = 0;
      for (int i = 0; i < 100 && cnt_done < 5; i++) begin
         @(negedge clk);
         if (go[0]) cnt_go++;
         if (done[0] != '0) cnt_done++;
      end
      req[0] = '0;
      check("rr_done_count", 32'(cnt_done), 32'(5));
      check("rr_go_count",   32'(cnt_go),   32'(5));

      // Single transaction, engine wt=0.
      push_exp(0, 1'b0, 2'd1);
      run_one(0, 4'b0010, 40, go_off, comp_off, bm, n_go, gg);
      check("single_go_cycle",   32'(go_off),   32'(1));
      check("single_gnt",        32'(gg),       32'(4'b0010));
      check("single_done_cycle", 32'(comp_off), 32'(5));
      check("single_busy",       32'(bm[5:0]),  32'(6'b111110));
      check("single_go_count",   32'(n_go),     32'(1));

      // Back-to-back: req presented in the first IDLE cycle is granted next cycle.
      push_exp(0, 1'b0, 2'd1);
      run_one(0, 4'b0010, 40, go_off, comp_off, bm, n_go, gg);
      check("b2b_go_cycle",   32'(go_off),   32'(1));
      check("b2b_done_cycle", 32'(comp_off), 32'(5));

      // Wait stretch: 20 extra engine wait cycles.
      extra[0] = 20;
      push_exp(0, 1'b0, 2'd2);
      run_one(0, 4'b0100, 80, go_off, comp_off, bm, n_go, gg);
      extra[0] = 0;
      check("stretch_done_cycle", 32'(comp_off), 32'(25));
      check("stretch_go_count",   32'(n_go),     32'(1));
      check("stretch_gnt",        32'(gg),       32'(4'b0100));

      // Reset in the middle of WAIT_DS.
      extra[0] = 30;
      @(negedge clk);
      req[0] = 4'b0010;
      repeat (6) @(negedge clk);
      check("pre_reset_busy", 32'(busy[0]), 32'(1));
      rst = 1'b0;
      #1;
      check("async_rst_gnt",    32'(gnt[0]),    32'(0));
      check("async_rst_gnt_id", 32'(gnt_id[0]), 32'(0));
      check("async_rst_done",   32'(done[0]),   32'(0));
      check("async_rst_err",    32'(err[0]),    32'(0));
      check("async_rst_go",     32'(go[0]),     32'(0));
      check("async_rst_busy",   32'(busy[0]),   32'(0));
      req[0] = '0;
      @(negedge clk);
      rst      = 1'b1;
      extra[0] = 0;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 32'(busy[0]), 32'(0));
      check("post_rst_gnt",  32'(gnt[0]),  32'(0));

      // The pointer is back at 0, so requester 0 wins over requester 3.
      push_exp(0, 1'b0, 2'd0);
      run_one(0, 4'b1001, 40, go_off, comp_off, bm, n_go, gg);
      check("post_rst_first_gnt", 32'(gg),       32'(4'b0001));
      check("post_rst_done",      32'(comp_off), 32'(5));
      push_exp(0, 1'b0, 2'd3);
      run_one(0, 4'b1000, 40, go_off, comp_off, bm, n_go, gg);
      check("post_rst_second_gnt", 32'(gg), 32'(4'b1000));

      // Timeout (TIMEOUT=8) with the engine stuck in WAIT.
      stuck[1] = 1'b1;
      push_exp(1, 1'b1, 2'd2);
      run_one(1, 4'b0100, 40, go_off, comp_off, bm, n_go, gg);
      check("tmo_go_cycle",  32'(go_off),   32'(1));
      check("tmo_gnt",       32'(gg),       32'(4'b0100));
      check("tmo_err_cycle", 32'(comp_off), 32'(10));

      // A new request is not issued while the engine still shows rd.
      push_exp(1, 1'b0, 2'd2);
      @(negedge clk);
      req[1] = 4'b0100;
      cnt_go = 0;
      repeat (12) begin
         @(negedge clk);
         if (go[1]) cnt_go++;
      end
      check("stuck_no_go", 32'(cnt_go),  32'(0));
      check("stuck_idle",  32'(busy[1]), 32'(0));
      stuck[1] = 1'b0;
      cnt_done = 0;
      for (int i = 0; i < 30 && cnt_done == 0; i++) begin
         @(negedge clk);
         if ((done[1] | err[1]) != '0) cnt_done++;
      end
      req[1] = '0;
      check("recover_served", 32'(cnt_done), 32'(1));

      // ds on the 8th WAIT_DS cycle ties with the timeout, and ds wins.
      extra[1] = 5;
      push_exp(1, 1'b0, 2'd0);
      run_one(1, 4'b0001, 40, go_off, comp_off, bm, n_go, gg);
      check("tie_done_cycle", 32'(comp_off), 32'(10));
      check("tie_gnt",        32'(gg),       32'(4'b0001));

      // ds one cycle too late: timeout.
      extra[1] = 6;
      push_exp(1, 1'b1, 2'd0);
      run_one(1, 4'b0001, 40, go_off, comp_off, bm, n_go, gg);
      check("late_err_cycle", 32'(comp_off), 32'(10));

      // ds one cycle early: done. The single requester is granted again.
      extra[1] = 4;
      push_exp(1, 1'b0, 2'd0);
      run_one(1, 4'b0001, 40, go_off, comp_off, bm, n_go, gg);
      check("early_done_cycle", 32'(comp_off), 32'(9));
      check("regrant_gnt",      32'(gg),       32'(4'b0001));
      extra[1] = 0;

      repeat (5) @(negedge clk);
      check("sb_drained0", 32'(exp_q0.size()), 32'(0));
      check("sb_drained1", 32'(exp_q1.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rd_arbiter.md
Name: rd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one read-handshake engine (go/wt in, rd/ds out) among N requesters.
- Selects one requester, pulses the engine's go input, and waits for the engine's done strobe.
- Returns a per-requester completion or timeout-error pulse.
- Sits between client blocks and the shared read engine; it is the only driver of the engine's go.

Parameters:
- N, 4: number of requesters (2..16).
- TIMEOUT, 64: maximum cycles spent in WAIT_DS before abort (>=4).
- Derived localparams (not overridable): IDW = clog2(N); CW = clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req  input  N  per-requester request level; held high until done or err.
- gnt  output  N  one-hot grant; high from ISSUE through RELEASE inclusive.
- gnt_id  output  IDW  binary index of current grantee; 0 when idle.
- done  output  N  one-cycle completion pulse to the grantee.
- err  output  N  one-cycle timeout pulse to the grantee.
- busy  output  1  high in every state except IDLE.
- go  output  1  to read engine; one-cycle start pulse.
- eng_rd  input  1  read engine rd (engine in READ or WAIT).
- eng_ds  input  1  read engine ds (engine in DONE, one cycle).

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, gnt_id=0, done=0, err=0, go=0, busy=0, rr pointer=0, counter=0. Reset mid-transaction aborts with no done or err pulse.
- States: IDLE, ISSUE, WAIT_DS, RELEASE. All outputs are registered or decoded from state/registers only; no combinational path from inputs to outputs.
- IDLE:
  - If req!=0 and eng_rd=0 and eng_ds=0, select the winner, latch gnt/gnt_id, and go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection: the first set bit of req, searching upward from index ptr and wrapping modulo N.
- ISSUE:
  - go=1 for exactly this cycle.
  - Counter cleared.
  - Always go to WAIT_DS next.
  - eng_ds in ISSUE is ignored.
- WAIT_DS:
  - Counter increments each cycle.
  - eng_ds=1: go to RELEASE with status OK.
  - Else if counter==TIMEOUT-1: go to RELEASE with status ERR.
  - If eng_ds and timeout occur in the same cycle, eng_ds wins (OK).
- RELEASE:
  - OK status: done[gnt_id]=1 for this cycle.
  - ERR status: err[gnt_id]=1 for this cycle.
  - gnt is still asserted.
  - ptr <= (gnt_id+1) mod N.
  - Next state IDLE; gnt and gnt_id clear on entry to IDLE.
- Grant stability:
  - gnt never changes between ISSUE and RELEASE.
  - req changes during a transaction do not affect it; if the grantee drops req, the transaction still completes and done/err still pulse.
- Latency: req seen in IDLE at cycle 0 gives gnt and go at cycle 1. With engine wt=0, eng_ds arrives at cycle 4, done at cycle 5, IDLE at cycle 6. Earliest next gnt is cycle 7.
- After an ERR, IDLE holds off until the engine shows eng_rd=0 and eng_ds=0, so no go is issued while the engine is stuck.
- Single requester: the same index is re-granted each transaction.
- Counter width CW; the counter saturates and does not wrap.

Test Plan:
- Single transaction: req=4'b0010, engine wt=0.
  - gnt=4'b0010 and go=1 at cycle 1.
  - done=4'b0010 pulse at cycle 5.
  - busy high for cycles 1-5.
  - err never asserts.
- Round robin: req=4'b1111 held, 4 transactions.
  - Grant order is 0,1,2,3, then 0 again.
  - Each gnt_id matches gnt.
  - Exactly one done pulse per grant.
- Wait stretch: wt held high 20 cycles.
  - gnt is stable throughout.
  - done arrives 20 cycles later than the wt=0 case.
  - No err.
- Timeout: TIMEOUT=8, wt stuck high.
  - err[grantee] pulses after 8 WAIT_DS cycles; done stays 0.
  - No new go while eng_rd=1.
  - After wt releases and the engine returns idle, the next request is served.
- Tie: eng_ds asserted on the cycle the counter hits TIMEOUT-1 -> done pulses, err=0.
- Reset mid-WAIT_DS: rst low for 1 cycle.
  - All outputs are 0 immediately (async) and stay 0 after release.
  - ptr=0, so req=4'b1001 is granted to index 0 first.
